// File: rtl/count_pkg.sv
// Shared types and defaults for the programmable counter.
// Mode encoding matches the register map used by the timer and sequencing blocks.
package count_pkg;

    typedef enum logic [1:0] {
        CNT_UP      = 2'b00,
        CNT_DOWN    = 2'b01,
        CNT_UPDOWN  = 2'b10,
        CNT_ONESHOT = 2'b11
    } count_mode_e;

    localparam int unsigned COUNT_WIDTH_DEF = 8;
    localparam int unsigned PRESC_W_DEF     = 8;

    // Direction as seen outside: only the ping-pong mode exposes the internal state.
    function automatic logic dir_view(input count_mode_e m, input logic dir_state);
        logic d;
        case (m)
            CNT_UP:      d = 1'b1;
            CNT_DOWN:    d = 1'b0;
            CNT_UPDOWN:  d = dir_state;
            CNT_ONESHOT: d = 1'b1;
            default:     d = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Prescaler for count_prog: ticks once every presc+1 enabled cycles.
// Holds its count while en is low so no tick is lost or duplicated.
module count_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick = (cnt_q == presc);

    // Next prescaler count: clear wins, then restart on tick, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_prog.sv
// Programmable counter: wrap limit, four counting modes, prescaler,
// synchronous clear/load and a one-cycle terminal-count pulse.
module count_prog
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = COUNT_WIDTH_DEF,
    parameter int unsigned PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   mod_max,
    input  count_mode_e        mode,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   val,
    output logic               tc,
    output logic               dir,
    output logic               done
);

    logic [WIDTH-1:0] val_q, val_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;
    logic             dir_out_q, dir_out_d;
    logic             done_q, done_d;
    logic             tick_s;
    logic             step_s;

    count_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr | load),
        .presc (presc),
        .tick  (tick_s)
    );

    assign step_s = en & tick_s;

    // Next-state logic; clr/load pre-empt any step, so a coincident terminal step never pulses tc.
    always_comb begin
        val_d  = val_q;
        dir_d  = dir_q;
        done_d = done_q;
        tc_d   = 1'b0;
        if (clr) begin
            val_d  = '0;
            dir_d  = 1'b1;
            done_d = 1'b0;
        end else if (load) begin
            val_d  = load_val;
            dir_d  = 1'b1;
            done_d = 1'b0;
        end else if (step_s) begin
            case (mode)
                CNT_UP: begin
                    if (val_q >= mod_max) begin
                        val_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        val_d = val_q + WIDTH'(1);
                    end
                end
                CNT_DOWN: begin
                    if (val_q == '0) begin
                        val_d = mod_max;
                        tc_d  = 1'b1;
                    end else begin
                        val_d = val_q - WIDTH'(1);
                    end
                end
                CNT_UPDOWN: begin
                    // A zero limit degenerates to a stuck-at-zero counter that turns on every step.
                    if (mod_max == '0) begin
                        val_d = '0;
                        tc_d  = 1'b1;
                    end else if (dir_q && (val_q >= mod_max)) begin
                        dir_d = 1'b0;
                        val_d = val_q - WIDTH'(1);
                        tc_d  = 1'b1;
                    end else if (!dir_q && (val_q == '0)) begin
                        dir_d = 1'b1;
                        val_d = WIDTH'(1);
                        tc_d  = 1'b1;
                    end else if (dir_q) begin
                        val_d = val_q + WIDTH'(1);
                    end else begin
                        val_d = val_q - WIDTH'(1);
                    end
                end
                CNT_ONESHOT: begin
                    if (done_q) begin
                        val_d = val_q;
                    end else if (val_q >= mod_max) begin
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                    end else begin
                        val_d = val_q + WIDTH'(1);
                    end
                end
                default: begin
                    val_d = val_q;
                end
            endcase
        end else begin
            val_d = val_q;
        end
        dir_out_d = dir_view(mode, dir_d);
    end

    // Counter state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q     <= '0;
            tc_q      <= 1'b0;
            dir_q     <= 1'b1;
            dir_out_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            val_q     <= val_d;
            tc_q      <= tc_d;
            dir_q     <= dir_d;
            dir_out_q <= dir_out_d;
            done_q    <= done_d;
        end
    end

    assign val  = val_q;
    assign tc   = tc_q;
    assign dir  = dir_out_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_prog.sv
// Scoreboard bench for count_prog (WIDTH=4, PRESC_W=4): stimulus pushes the
// expected post-edge outputs, a monitor pops and compares after each rising edge.
module tb_count_prog;
    import count_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        load;
    logic [3:0]  load_val;
    logic [3:0]  mod_max;
    count_mode_e mode;
    logic [3:0]  presc;
    logic [3:0]  val;
    logic        tc;
    logic        dir;
    logic        done;

    typedef struct {
        logic [3:0] val;
        logic       tc;
        logic       dir;
        logic       done;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    count_prog #(
        .WIDTH   (4),
        .PRESC_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .mod_max  (mod_max),
        .mode     (mode),
        .presc    (presc),
        .val      (val),
        .tc       (tc),
        .dir      (dir),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Monitor: every rising edge presents a new output word.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_vec++;
            if (val !== mon_e.val || tc !== mon_e.tc || dir !== mon_e.dir || done !== mon_e.done) begin
                n_err++;
                $display("FAIL %s: got val=%0d tc=%0b dir=%0b done=%0b, expected val=%0d tc=%0b dir=%0b done=%0b",
                         mon_e.nm, val, tc, dir, done, mon_e.val, mon_e.tc, mon_e.dir, mon_e.done);
            end
        end
    end

    // Apply current inputs for one clock and queue the outputs expected after the edge.
    task automatic cyc(input logic [3:0] v, input logic t, input logic d, input logic dn, input string nm);
        exp_t x;
        x.val = v; x.tc = t; x.dir = d; x.done = dn; x.nm = nm;
        sb_q.push_back(x);
        @(negedge clk);
    endtask

    // Immediate comparison, used where outputs change without a clock edge.
    task automatic check_now(input logic [3:0] v, input logic t, input logic d, input logic dn, input string nm);
        n_vec++;
        if (val !== v || tc !== t || dir !== d || done !== dn) begin
            n_err++;
            $display("FAIL %s: got val=%0d tc=%0b dir=%0b done=%0b, expected val=%0d tc=%0b dir=%0b done=%0b",
                     nm, val, tc, dir, done, v, t, d, dn);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = 4'd0; mod_max = 4'd5; mode = CNT_UP; presc = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check_now(4'd0, 1'b0, 1'b1, 1'b0, "reset");
        rst = 1'b1;

        // CNT_UP, limit 5: 1..5 then wrap to 0 with tc
        en = 1'b1;
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "up1");
        cyc(4'd2, 1'b0, 1'b1, 1'b0, "up2");
        cyc(4'd3, 1'b0, 1'b1, 1'b0, "up3");
        cyc(4'd4, 1'b0, 1'b1, 1'b0, "up4");
        cyc(4'd5, 1'b0, 1'b1, 1'b0, "up5");
        cyc(4'd0, 1'b1, 1'b1, 1'b0, "up_wrap");
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "up_after_wrap");

        // Prescaler 2: step every 3rd enabled cycle, en gap of 4 stretches the period
        presc = 4'd2; clr = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "psc_clr");
        clr = 1'b0;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "psc_a");
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "psc_b");
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "psc_tick1");
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "psc_c");
        en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(4'd1, 1'b0, 1'b1, 1'b0, "psc_hold");
        en = 1'b1;
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "psc_resume");
        cyc(4'd2, 1'b0, 1'b1, 1'b0, "psc_tick2");

        // Ping-pong, limit 3
        presc = 4'd0; mod_max = 4'd3; mode = CNT_UPDOWN; clr = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "ud_clr");
        clr = 1'b0;
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "ud1");
        cyc(4'd2, 1'b0, 1'b1, 1'b0, "ud2");
        cyc(4'd3, 1'b0, 1'b1, 1'b0, "ud3");
        cyc(4'd2, 1'b1, 1'b0, 1'b0, "ud_turn_top");
        cyc(4'd1, 1'b0, 1'b0, 1'b0, "ud_dn1");
        cyc(4'd0, 1'b0, 1'b0, 1'b0, "ud_dn0");
        cyc(4'd1, 1'b1, 1'b1, 1'b0, "ud_turn_bot");
        cyc(4'd2, 1'b0, 1'b1, 1'b0, "ud_up2");

        // Ping-pong with zero limit: stuck at 0, tc every step
        mod_max = 4'd0; clr = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "ud0_clr");
        clr = 1'b0;
        for (int i = 0; i < 3; i++) cyc(4'd0, 1'b1, 1'b1, 1'b0, "ud0_tc");

        // CNT_DOWN from 2, limit 9
        mode = CNT_DOWN; mod_max = 4'd9; load_val = 4'd2; load = 1'b1;
        cyc(4'd2, 1'b0, 1'b0, 1'b0, "dn_load");
        load = 1'b0;
        cyc(4'd1, 1'b0, 1'b0, 1'b0, "dn1");
        cyc(4'd0, 1'b0, 1'b0, 1'b0, "dn0");
        cyc(4'd9, 1'b1, 1'b0, 1'b0, "dn_wrap");
        cyc(4'd8, 1'b0, 1'b0, 1'b0, "dn8");

        // Load above limit in CNT_UP wraps on the next step
        mode = CNT_UP; load_val = 4'd12; load = 1'b1;
        cyc(4'd12, 1'b0, 1'b1, 1'b0, "up_load12");
        load = 1'b0;
        cyc(4'd0, 1'b1, 1'b1, 1'b0, "up_over_wrap");

        // One-shot, limit 3
        mode = CNT_ONESHOT; mod_max = 4'd3; clr = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "os_clr");
        clr = 1'b0;
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "os1");
        cyc(4'd2, 1'b0, 1'b1, 1'b0, "os2");
        cyc(4'd3, 1'b0, 1'b1, 1'b0, "os3");
        cyc(4'd3, 1'b1, 1'b1, 1'b1, "os_done");
        for (int i = 0; i < 10; i++) cyc(4'd3, 1'b0, 1'b1, 1'b1, "os_hold");
        clr = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "os_reclr");
        clr = 1'b0;
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "os_restart");

        // Priority: clr beats load; load suppresses a terminal step
        mode = CNT_UP; mod_max = 4'd5; load_val = 4'd7; clr = 1'b1; load = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "clr_over_load");
        clr = 1'b0; load_val = 4'd5;
        cyc(4'd5, 1'b0, 1'b1, 1'b0, "load5");
        load_val = 4'd3;
        cyc(4'd3, 1'b0, 1'b1, 1'b0, "load_on_terminal");
        load = 1'b0;
        cyc(4'd4, 1'b0, 1'b1, 1'b0, "after_load_step");

        // Async reset mid-count with done set
        mode = CNT_ONESHOT; mod_max = 4'd1; clr = 1'b1;
        cyc(4'd0, 1'b0, 1'b1, 1'b0, "rst_setup_clr");
        clr = 1'b0;
        cyc(4'd1, 1'b0, 1'b1, 1'b0, "rst_setup1");
        cyc(4'd1, 1'b1, 1'b1, 1'b1, "rst_setup_done");
        #1;
        rst = 1'b0;
        #1;
        check_now(4'd0, 1'b0, 1'b1, 1'b0, "async_reset");
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);

        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_prog.md
# count_prog

Parametrised programmable counter. It generalises the free-running 4-bit incrementer to any width and adds a programmable wrap limit, four counting modes, a prescaler, synchronous clear/load and a terminal-count pulse. It is the shared timebase/event counter for the timer and sequencing blocks in the project.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- PRESC_W, 8, prescaler width in bits (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-low
- en  in  1  count enable; low freezes counter and prescaler
- clr  in  1  synchronous clear (highest priority)
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value applied on load
- mod_max  in  WIDTH  wrap/turn limit (inclusive)
- mode  in  2  counting mode, count_mode_e
- presc  in  PRESC_W  step every presc+1 enabled cycles
- val  out  WIDTH  current count
- tc  out  1  terminal-count pulse, one cycle
- dir  out  1  current direction, 1 = up
- done  out  1  one-shot finished flag

## Operation
- Priority per cycle: clr > load > step.
  - clr: val=0, dir=1, done=0, prescaler=0.
  - load: val=load_val, dir=1, done=0, prescaler=0.
- step = en && tick. tick is high when the prescaler count equals presc; the prescaler then restarts at 0. With presc=0, tick=1 on every enabled cycle.
- Modes (all arithmetic modulo 2^WIDTH, unsigned compares):
  - CNT_UP (00): if val ≥ mod_max, val←0 and tc. Otherwise val+1.
  - CNT_DOWN (01): if val==0, val←mod_max and tc. Otherwise val−1.
  - CNT_UPDOWN (10), ping-pong:
    - dir=1 and val ≥ mod_max: dir←0, val←val−1, tc.
    - dir=0 and val==0: dir←1, val←1, tc.
    - Otherwise step in the current dir.
    - mod_max==0: val stays 0, tc on every step.
  - CNT_ONESHOT (11): counts up. A step with val ≥ mod_max and done=0 holds val, sets done=1 and pulses tc. Steps are ignored while done=1.
- dir output: forced 1 in 00 and 11, forced 0 in 01, internal state in 10.
- A mode change takes effect on the next step. dir is not reset by a mode change.
- A loaded value above mod_max is accepted. The next step applies the rules above; in CNT_UP it wraps to 0 immediately.

## Timing
- Reset values: val=0, tc=0, dir=1, done=0, prescaler=0.
- All outputs are registered. val and tc update on the same clock edge as the step.
- tc is high for exactly one cycle per terminal event. With presc=0 and continuous wrap it can be high on consecutive steps (e.g. mod_max=0 in CNT_UP).
- Latency: clr/load is visible on val one cycle after it is sampled. The first step after load occurs presc+1 enabled cycles later.
- en low mid-period: the prescaler holds its count and resumes when en returns high. No tick is lost or duplicated.
- clr or load in the same cycle as a terminal step: the terminal step is suppressed and tc=0.
- Reset asserted mid-count: outputs go to reset values asynchronously. Release is synchronised externally.

## Structure
- Package count_pkg:
  - typedef enum logic [1:0] count_mode_e {CNT_UP, CNT_DOWN, CNT_UPDOWN, CNT_ONESHOT}
  - default parameter constants.
- Sub-module count_prescaler: PRESC_W counter with en, clr (driven by clr|load) and presc inputs; outputs tick.
- Top level holds the val/dir/done/tc registers and the next-state logic in a single combinational block.

## Test plan
- Reset and CNT_UP: WIDTH=4, mod_max=5, presc=0, en=1 → val 0,1,2,3,4,5,0. tc is high exactly in the cycle val becomes 0 after 5.
- Prescaler: presc=2, CNT_UP → val increments every 3rd cycle. Dropping en for 4 cycles extends the period by exactly 4 cycles.
- CNT_UPDOWN with mod_max=3 → val 0,1,2,3,2,1,0,1. dir toggles and tc pulses at the 3 and 0 turns. mod_max=0 → val stays 0 and tc pulses on every step.
- CNT_DOWN from load_val=2, mod_max=9 → 2,1,0,9,8, with tc when 9 appears. Load of 12 with mod_max=9 in CNT_UP → next val 0.
- CNT_ONESHOT with mod_max=3 → 0..3, then done=1, a single tc pulse, and val held at 3 for 10 more steps. clr → val=0, done=0, and counting restarts.
- Priority and reset: clr+load together → val=0. load during a terminal step → val=load_val, tc=0. rst asserted mid-count → all outputs at reset values immediately.
